instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer.sv | 118 +++++++++++
 tb/tb_instruction_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Fetches one 10-bit instruction word at a time and steps a 2-bit timestep
// (T0..T3) for an external controller. The controller ends the instruction
// with Clr. If Clr never arrives, the instruction is forcibly retired after T3
// and a sticky error is raised. Every output comes straight from a register,
// so there is no combinational path from any input to any output.

module instruction_sequencer (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic [9:0] Data,
   input  logic       InstValid,
   output logic       InstReady,
   input  logic       Clr,
   input  logic       Stall,
   output logic [9:0] INST,
   output logic [1:0] T,
   output logic       Busy,
   output logic       Done,
   output logic       Err,
   output logic [7:0] InstCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t     state_r;
   logic [9:0] inst_r;
   logic [1:0] t_r;
   logic [7:0] count_r;
   logic       err_r;
   logic       done_r;
   logic       busy_r;
   logic       ready_r;

   // Sequencer FSM; the status flags are loaded with the values of the state being entered
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_r <= S_IDLE;
         inst_r  <= 10'd0;
         t_r     <= 2'd0;
         count_r <= 8'd0;
         err_r   <= 1'b0;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (InstValid) begin
                  // The accept cycle itself is T0, so execution starts at T1
                  inst_r  <= Data;
                  t_r     <= 2'd1;
                  state_r <= S_EXEC;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end else begin
                  ready_r <= 1'b1;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            S_EXEC: begin
               if (Clr) begin
                  // Normal retire; Clr outranks Stall
                  t_r     <= 2'd0;
                  count_r <= count_r + 8'd1;
                  state_r <= S_DONE;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b0;
               end else if (Stall) begin
                  t_r     <= t_r;
               end else if (t_r != 2'd3) begin
                  t_r     <= t_r + 2'd1;
               end else begin
                  // Overran T3 without Clr: retire anyway, no Done pulse
                  err_r   <= 1'b1;
                  t_r     <= 2'd0;
                  count_r <= count_r + 8'd1;
                  state_r <= S_IDLE;
                  done_r  <= 1'b0;
                  busy_r  <= 1'b0;
                  ready_r <= 1'b1;
               end
            end
            S_DONE: begin
               t_r     <= 2'd0;
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
            default: begin
               // Unused encoding: recover to IDLE
               t_r     <= 2'd0;
               state_r <= S_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign InstReady = ready_r;
   assign INST      = inst_r;
   assign T         = t_r;
   assign Busy      = busy_r;
   assign Done      = done_r;
   assign Err       = err_r;
   assign InstCount = count_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed, table-driven bench for instruction_sequencer.
// Each record holds the inputs driven before a rising edge and the outputs
// expected just after that edge.

module tb_instruction_sequencer;

   logic       clk;
   logic       resetn;
   logic [9:0] data;
   logic       inst_valid;
   logic       inst_ready;
   logic       clr;
   logic       stall;
   logic [9:0] inst;
   logic [1:0] t;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] inst_count;

   int n_checks = 0;
   int n_pass   = 0;

   instruction_sequencer dut (
      .Clock     (clk),
      .Resetn    (resetn),
      .Data      (data),
      .InstValid (inst_valid),
      .InstReady (inst_ready),
      .Clr       (clr),
      .Stall     (stall),
      .INST      (inst),
      .T         (t),
      .Busy      (busy),
      .Done      (done),
      .Err       (err),
      .InstCount (inst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rstn;
      logic       valid;
      logic       c;
      logic       s;
      logic [9:0] d;
      logic [9:0] e_inst;
      logic [1:0] e_t;
      logic       e_rdy;
      logic       e_busy;
      logic       e_done;
      logic       e_err;
      logic [7:0] e_cnt;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rstn, input logic valid, input logic c,
                               input logic s, input logic [9:0] d,
                               input logic [9:0] e_inst, input logic [1:0] e_t,
                               input logic e_rdy, input logic e_busy, input logic e_done,
                               input logic e_err, input logic [7:0] e_cnt);
      vec_t v;
      v.rstn = rstn; v.valid = valid; v.c = c; v.s = s; v.d = d;
      v.e_inst = e_inst; v.e_t = e_t; v.e_rdy = e_rdy; v.e_busy = e_busy;
      v.e_done = e_done; v.e_err = e_err; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   initial begin
      resetn = 1'b0; data = 10'd0; inst_valid = 1'b0; clr = 1'b0; stall = 1'b0;

      //          rstn  vld   clr   stl   data     inst     t     rdy   busy  done  err   cnt
      // reset
      vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      // normal retire, Clr at T2
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h2A5, 10'h2A5, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h2A5, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h2A5, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h2A5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
      // idle without valid: nothing changes
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF, 10'h2A5, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
      // stall three cycles at T1, then Clr at T3
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h155, 10'h155, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 10'h155, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 10'h155, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 10'h000, 10'h155, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h155, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h155, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h155, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h155, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2));
      // overrun: no Clr, forced retire after T3
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h0AA, 10'h0AA, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h0AA, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h0AA, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h0AA, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h0AA, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3));
      // back-to-back with InstValid held; Clr+Stall together at T1 (Clr wins)
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h111, 10'h111, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd3));
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 10'h222, 10'h111, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd4));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h222, 10'h111, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h222, 10'h222, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd4));
      vq.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h333, 10'h222, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h333, 10'h222, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5));
      // mid-EXEC reset at T2 (Clr asserted too), then immediate accept
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h0F0, 10'h0F0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h0F0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5));
      vq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 10'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h3C3, 10'h3C3, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h3C3, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h3C3, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1));
      // reset while in DONE
      vq.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h001, 10'h001, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      vq.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h001, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2));
      vq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0));

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         resetn     = vq[i].rstn;
         inst_valid = vq[i].valid;
         clr        = vq[i].c;
         stall      = vq[i].s;
         data       = vq[i].d;
         @(posedge clk);
         #1;
         check("INST",      i, 32'(inst),       32'(vq[i].e_inst));
         check("T",         i, 32'(t),          32'(vq[i].e_t));
         check("InstReady", i, 32'(inst_ready), 32'(vq[i].e_rdy));
         check("Busy",      i, 32'(busy),       32'(vq[i].e_busy));
         check("Done",      i, 32'(done),       32'(vq[i].e_done));
         check("Err",       i, 32'(err),        32'(vq[i].e_err));
         check("InstCount", i, 32'(inst_count), 32'(vq[i].e_cnt));
      end

      // Wrap: 256 retirements of accept / Clr at T1 / DONE bring InstCount back to 0
      for (int k = 1; k <= 256; k++) begin
         @(negedge clk);
         resetn = 1'b1; inst_valid = 1'b1; clr = 1'b0; stall = 1'b0; data = 10'(k);
         @(negedge clk);
         inst_valid = 1'b0; clr = 1'b1;
         @(negedge clk);
         clr = 1'b0;
         @(posedge clk);
         #1;
         if (k == 255) check("wrap_255", k, 32'(inst_count), 32'd255);
         if (k == 256) begin
            check("wrap_0",    k, 32'(inst_count), 32'd0);
            check("wrap_err",  k, 32'(err),        32'd0);
            check("wrap_rdy",  k, 32'(inst_ready), 32'd1);
         end
      end

      // Stall held at T3 keeps the instruction alive; releasing it overruns
      @(negedge clk);
      inst_valid = 1'b1; data = 10'h0C3;
      @(negedge clk);
      inst_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      stall = 1'b1;
      @(posedge clk);
      #1;
      check("stall_t3_t",    0, 32'(t),    32'd3);
      check("stall_t3_busy", 0, 32'(busy), 32'd1);
      check("stall_t3_err",  0, 32'(err),  32'd0);
      @(negedge clk);
      stall = 1'b0;
      @(posedge clk);
      #1;
      check("ovr_err",  0, 32'(err),        32'd1);
      check("ovr_done", 0, 32'(done),       32'd0);
      check("ovr_cnt",  0, 32'(inst_count), 32'd1);
      check("ovr_t",    0, 32'(t),          32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
